// File: rtl/sram_1rw_init_if.sv
// Request/response bundle for sram_1rw_init: ready/valid request side plus read return.
// The master drives requests and the clear pulse; the slave returns ready, busy and read data.
interface sram_1rw_init_if #(
    parameter int BITS       = 8,
    parameter int ADDR_WIDTH = 9
) ();
    logic                  ce_in;
    logic                  we_in;
    logic [ADDR_WIDTH-1:0] addr_in;
    logic [BITS-1:0]       wd_in;
    logic [BITS-1:0]       w_mask_in;
    logic                  init_in;
    logic                  ready_out;
    logic                  init_busy_out;
    logic [BITS-1:0]       rd_out;
    logic                  rd_valid_out;

    modport master (
        output ce_in, we_in, addr_in, wd_in, w_mask_in, init_in,
        input  ready_out, init_busy_out, rd_out, rd_valid_out
    );

    modport slave (
        input  ce_in, we_in, addr_in, wd_in, w_mask_in, init_in,
        output ready_out, init_busy_out, rd_out, rd_valid_out
    );
endinterface

// File: rtl/sram_1rw_init.sv
// Single-port synchronous SRAM with per-bit write mask, a hardware clear engine that fills
// every word with INIT_VALUE after reset or on request, and an optional read output register.
module sram_1rw_init #(
    parameter int              BITS               = 8,
    parameter int              WORD_DEPTH         = 512,
    parameter int              ADDR_WIDTH         = 9,
    parameter logic [BITS-1:0] INIT_VALUE         = '0,
    parameter bit              OUT_REG            = 1'b0,
    parameter bit              corrupt_mem_on_X_p = 1'b1
) (
    input  logic               clk,
    input  logic               reset_in,
    sram_1rw_init_if.slave     bus
);
    typedef enum logic {
        S_CLEAR,
        S_READY
    } state_e;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(WORD_DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(WORD_DEPTH);

    state_e                state;
    logic [ADDR_WIDTH-1:0] clr_cnt;
    logic [BITS-1:0]       mem [WORD_DEPTH];
    logic [BITS-1:0]       s1_data;
    logic                  s1_valid;

    logic                  addr_ok;
    logic                  accept;
    logic                  wr_accept;
    logic                  rd_accept;
    logic                  x_hit;
    logic [BITS-1:0]       rd_word;

    // init_in wins over a same-cycle request, so the request is simply not accepted.
    assign addr_ok   = ({1'b0, bus.addr_in} < DEPTH_EXT);
    assign accept    = bus.ce_in & (state == S_READY) & ~bus.init_in;
    assign wr_accept = accept & bus.we_in;
    assign rd_accept = accept & ~bus.we_in;
    assign rd_word   = addr_ok ? mem[bus.addr_in] : INIT_VALUE;
    assign x_hit     = corrupt_mem_on_X_p && accept && $isunknown({bus.we_in, bus.addr_in});

    // NOTE: the array has no reset branch; a reset must leave contents untouched and the
    // clear engine, not the reset, is what gives every word a known value.
    always_ff @(posedge clk) begin
        if (!reset_in) begin
            if (state == S_CLEAR) begin
                mem[clr_cnt] <= INIT_VALUE;
            end else if (x_hit) begin
                for (int i = 0; i < WORD_DEPTH; i++) mem[i] <= 'x;
            end else if (wr_accept && addr_ok) begin
                mem[bus.addr_in] <= (bus.wd_in & bus.w_mask_in)
                                  | (mem[bus.addr_in] & ~bus.w_mask_in);
            end
        end
    end

    // NOTE: every register below is updated with <= so all of them see pre-edge values.
    always_ff @(posedge clk) begin
        if (reset_in) begin
            state             <= S_CLEAR;
            clr_cnt           <= '0;
            bus.ready_out     <= 1'b0;
            bus.init_busy_out <= 1'b1;
            bus.rd_out        <= '0;
            bus.rd_valid_out  <= 1'b0;
            s1_data           <= '0;
            s1_valid          <= 1'b0;
        end else begin
            case (state)
                S_CLEAR: begin
                    // Counter parks on the last word so odd depths never index past the array.
                    if (clr_cnt == LAST_ADDR) begin
                        state             <= S_READY;
                        bus.ready_out     <= 1'b1;
                        bus.init_busy_out <= 1'b0;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                    end
                end
                S_READY: begin
                    if (bus.init_in) begin
                        state             <= S_CLEAR;
                        clr_cnt           <= '0;
                        bus.ready_out     <= 1'b0;
                        bus.init_busy_out <= 1'b1;
                    end
                end
                default: state <= S_CLEAR;
            endcase

            // Read return path runs independently of the FSM so a re-clear lets reads drain.
            if (OUT_REG) begin
                s1_valid         <= rd_accept;
                bus.rd_valid_out <= s1_valid;
                if (rd_accept) s1_data    <= rd_word;
                if (s1_valid)  bus.rd_out <= s1_data;
            end else begin
                bus.rd_valid_out <= rd_accept;
                if (rd_accept) bus.rd_out <= rd_word;
            end
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!reset_in && x_hit)
            $warning("sram_1rw_init: X on we_in/addr_in of accepted request, array corrupted");
    end
`endif
endmodule

// File: tb/tb_sram_1rw_init.sv
// Randomized bench for sram_1rw_init: three instances (default, OUT_REG=1, depth-5 odd size)
// share one stimulus stream and are compared every cycle against a word-level reference model.
module tb_sram_1rw_init;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       ce;
    logic       we;
    logic       init;
    logic [8:0] addr;
    logic [7:0] wd;
    logic [7:0] mask;

    sram_1rw_init_if #(.BITS(8), .ADDR_WIDTH(9)) if0 ();
    sram_1rw_init_if #(.BITS(8), .ADDR_WIDTH(9)) if1 ();
    sram_1rw_init_if #(.BITS(8), .ADDR_WIDTH(3)) if2 ();

    assign if0.ce_in = ce;  assign if0.we_in = we;  assign if0.addr_in = addr;
    assign if0.wd_in = wd;  assign if0.w_mask_in = mask;  assign if0.init_in = init;
    assign if1.ce_in = ce;  assign if1.we_in = we;  assign if1.addr_in = addr;
    assign if1.wd_in = wd;  assign if1.w_mask_in = mask;  assign if1.init_in = init;
    assign if2.ce_in = ce;  assign if2.we_in = we;  assign if2.addr_in = addr[2:0];
    assign if2.wd_in = wd;  assign if2.w_mask_in = mask;  assign if2.init_in = init;

    sram_1rw_init #(.OUT_REG(1'b0)) u0 (.clk(clk), .reset_in(rst), .bus(if0.slave));
    sram_1rw_init #(.OUT_REG(1'b1)) u1 (.clk(clk), .reset_in(rst), .bus(if1.slave));
    sram_1rw_init #(.WORD_DEPTH(5), .ADDR_WIDTH(3), .INIT_VALUE(8'h3C), .OUT_REG(1'b0)) u2 (
        .clk(clk), .reset_in(rst), .bus(if2.slave));

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h (edge %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference model: memory image, remaining clear cycles, and a list of expected read returns.
    typedef struct {
        int         inst;
        int         due;
        logic [7:0] data;
    } rd_exp_t;

    rd_exp_t    exp_q[$];
    logic [7:0] m_mem [3][512];
    int         clear_left [3];
    logic [7:0] last_rd [3];

    function automatic int depth_of(input int k);
        return (k == 2) ? 5 : 512;
    endfunction

    function automatic logic [7:0] init_of(input int k);
        return (k == 2) ? 8'h3C : 8'h00;
    endfunction

    task automatic model_edge();
        if (rst) exp_q.delete();
        for (int k = 0; k < 3; k++) begin
            int         dep;
            int         a;
            logic [7:0] iv;
            dep = depth_of(k);
            iv  = init_of(k);
            a   = (k == 2) ? int'(addr[2:0]) : int'(addr);
            if (rst) begin
                clear_left[k] = dep;
                last_rd[k]    = 8'h00;
            end else if (clear_left[k] > 0) begin
                clear_left[k]--;
                if (clear_left[k] == 0)
                    for (int i = 0; i < dep; i++) m_mem[k][i] = iv;
            end else if (init) begin
                clear_left[k] = dep;
            end else if (ce) begin
                if (we) begin
                    if (a < dep) m_mem[k][a] = (wd & mask) | (m_mem[k][a] & ~mask);
                end else begin
                    exp_q.push_back('{inst: k, due: cyc + ((k == 1) ? 1 : 0),
                                      data: (a < dep) ? m_mem[k][a] : iv});
                end
            end
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 3; k++) begin
            logic       rdy, bsy, v, ev;
            logic [7:0] d, ed;
            int         hit;
            case (k)
                0:       begin rdy = if0.ready_out; bsy = if0.init_busy_out; v = if0.rd_valid_out; d = if0.rd_out; end
                1:       begin rdy = if1.ready_out; bsy = if1.init_busy_out; v = if1.rd_valid_out; d = if1.rd_out; end
                default: begin rdy = if2.ready_out; bsy = if2.init_busy_out; v = if2.rd_valid_out; d = if2.rd_out; end
            endcase
            ev  = 1'b0;
            ed  = last_rd[k];
            hit = -1;
            foreach (exp_q[i]) if (exp_q[i].inst == k && exp_q[i].due == cyc) hit = i;
            if (hit >= 0) begin
                ev         = 1'b1;
                ed         = exp_q[hit].data;
                last_rd[k] = ed;
                exp_q.delete(hit);
            end
            check($sformatf("u%0d_ready", k),    32'(rdy), 32'(clear_left[k] == 0));
            check($sformatf("u%0d_busy", k),     32'(bsy), 32'(clear_left[k] != 0));
            check($sformatf("u%0d_rd_valid", k), 32'(v),   32'(ev));
            check($sformatf("u%0d_rd_out", k),   32'(d),   32'(ed));
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        cyc++;
        model_edge();
        #1;
        check_all();
    endtask

    task automatic drive(input logic c, input logic w, input logic [8:0] a,
                         input logic [7:0] d, input logic [7:0] m);
        ce = c; we = w; addr = a; wd = d; mask = m; init = 1'b0; rst = 1'b0;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 9'h000, 8'h00, 8'h00);
    endtask

    // Runs until the default instance is ready, issuing random reads that must all be ignored
    // while clearing; reports how many edges each depth took.
    task automatic wait_clear(input string tag);
        int n  = 0;
        int n2 = -1;
        do begin
            drive(1'($urandom_range(0, 1)), 1'b0, 9'($urandom_range(0, 15)),
                  8'($urandom), 8'($urandom));
            cycle();
            n++;
            if (n2 < 0 && if2.ready_out) n2 = n;
        end while (!if0.ready_out && n < 600);
        check({tag, "_len512"}, 32'(n), 32'd512);
        check({tag, "_len5"}, 32'(n2), 32'd5);
        idle();
    endtask

    initial begin
        idle();
        rst = 1'b1;
        repeat (3) cycle();
        check("rst_busy", 32'(if0.init_busy_out), 32'd1);
        check("rst_ready", 32'(if1.ready_out), 32'd0);
        rst = 1'b0;
        wait_clear("clear_after_reset");

        // Odd-depth instance: out-of-range write dropped, reads return INIT_VALUE.
        drive(1'b1, 1'b1, 9'd6, 8'hFF, 8'hFF); cycle();
        drive(1'b1, 1'b0, 9'd6, 8'h00, 8'h00); cycle();
        check("u2_rd_oob", 32'(if2.rd_out), 32'h3C);
        drive(1'b1, 1'b0, 9'd4, 8'h00, 8'h00); cycle();
        check("u2_rd_4", 32'(if2.rd_out), 32'h3C);

        drive(1'b1, 1'b0, 9'h1FF, 8'h00, 8'h00); cycle();
        check("rd_1ff_valid", 32'(if0.rd_valid_out), 32'd1);
        check("rd_1ff_data", 32'(if0.rd_out), 32'h00);

        // Masked read-modify-write.
        drive(1'b1, 1'b1, 9'h010, 8'hA5, 8'hFF); cycle();
        drive(1'b1, 1'b1, 9'h010, 8'h3C, 8'h0F); cycle();
        drive(1'b1, 1'b0, 9'h010, 8'h00, 8'h00); cycle();
        check("rmw_u0", 32'(if0.rd_out), 32'hAC);
        idle(); cycle();
        check("rmw_u1", 32'(if1.rd_out), 32'hAC);

        // Back-to-back reads through the two-cycle pipeline.
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, 1'b1, 9'(i), 8'(8'h11 * i), 8'hFF); cycle();
        end
        for (int i = 0; i < 4; i++) begin
            if (i < 3) drive(1'b1, 1'b0, 9'(i + 1), 8'h00, 8'h00);
            else idle();
            cycle();
            if (i >= 1) begin
                check("b2b_u1_valid", 32'(if1.rd_valid_out), 32'd1);
                check("b2b_u1_data", 32'(if1.rd_out), 32'h11 * i);
            end
        end

        // Re-clear request with a colliding write that must be dropped.
        drive(1'b1, 1'b1, 9'd7, 8'h5A, 8'hFF); cycle();
        drive(1'b1, 1'b1, 9'd8, 8'hFF, 8'hFF); init = 1'b1; cycle();
        wait_clear("reinit");
        drive(1'b1, 1'b0, 9'd7, 8'h00, 8'h00); cycle();
        check("reinit_rd7", 32'(if0.rd_out), 32'h00);
        drive(1'b1, 1'b0, 9'd8, 8'h00, 8'h00); cycle();
        check("reinit_rd8", 32'(if0.rd_out), 32'h00);

        // Reset 100 cycles into a clear.
        idle(); init = 1'b1; cycle();
        idle(); repeat (100) cycle();
        rst = 1'b1; repeat (2) cycle();
        rst = 1'b0;
        wait_clear("mid_clear_reset");

        // Read in flight on the registered instance, then reset: no return pulse.
        drive(1'b1, 1'b0, 9'd1, 8'h00, 8'h00); cycle();
        idle(); rst = 1'b1; cycle();
        check("flush_u1_valid", 32'(if1.rd_valid_out), 32'd0);
        cycle();
        check("flush_u1_valid2", 32'(if1.rd_valid_out), 32'd0);
        rst = 1'b0;
        wait_clear("after_flush");

        // Random traffic with occasional re-clear and reset.
        for (int i = 0; i < 1500; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 7) == 0) ? 9'($urandom) : 9'($urandom_range(0, 15)),
                  8'($urandom), ($urandom_range(0, 1) == 0) ? 8'hFF : 8'($urandom));
            init = 1'($urandom_range(0, 999) == 0);
            rst  = 1'($urandom_range(0, 799) == 0);
            cycle();
        end
        idle();
        repeat (3) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/sram_1rw_init.md
Name: sram_1rw_init

Overview:
- Parametrised single-port (1RW) synchronous SRAM model with per-bit write mask.
- Adds a hardware clear engine that fills every word with INIT_VALUE after reset or on request.
- Adds a ready/valid request interface and an optional output register stage.
- Successor to the fixed 8x512 1RW macro model; drops in wherever blocks need a known-clean scratch memory without a software clear loop.

Parameters:
BITS, 8, data word width
WORD_DEPTH, 512, number of words (any value >= 2, need not be a power of two)
ADDR_WIDTH, 9, address width; must satisfy 2**ADDR_WIDTH >= WORD_DEPTH
INIT_VALUE, 0, BITS-wide value written to every word by the clear engine
OUT_REG, 0, 0 = read data one cycle after accept; 1 = extra output register, two cycles
corrupt_mem_on_X_p, 1, simulation only: X on we_in/addr_in of an accepted request corrupts the whole array

Ports:
clk  input  1  clock, all logic on rising edge
reset_in  input  1  synchronous, active-high reset
ce_in  input  1  request valid
we_in  input  1  1 = write, 0 = read
addr_in  input  ADDR_WIDTH  word address
wd_in  input  BITS  write data
w_mask_in  input  BITS  per-bit write enable, 1 = write that bit
init_in  input  1  single-cycle pulse: request full re-clear
ready_out  output  1  request accepted this cycle when ce_in & ready_out
init_busy_out  output  1  clear engine active
rd_out  output  BITS  read data
rd_valid_out  output  1  one-cycle pulse, rd_out carries a read result

Behaviour:
- Reset values: ready_out=0, init_busy_out=1, rd_out=0, rd_valid_out=0; pipeline valids cleared; FSM=CLEAR, clear counter=0. While reset_in=1 no memory write occurs.
- FSM states: CLEAR, READY.
- CLEAR: each cycle writes INIT_VALUE to mem[counter] and increments the counter. The first edge with reset_in=0 writes word 0. The write to word WORD_DEPTH-1 happens on edge WORD_DEPTH, which also moves the FSM to READY. ready_out=1 from that point (WORD_DEPTH cycles after deassertion). The counter never exceeds WORD_DEPTH-1 (non-power-of-two safe).
- In CLEAR: ready_out=0, init_busy_out=1. ce_in is ignored: no memory effect, no rd_valid_out. init_in is ignored.
- READY: ready_out=1, init_busy_out=0.
  - init_in=1 moves the FSM to CLEAR with counter=0 on the next edge. A ce_in in the same cycle is dropped; init has priority.
- Write accept (ce_in & ready_out & we_in): mem[addr] <= (wd_in & w_mask_in) | (mem[addr] & ~w_mask_in).
- Read accept (ce_in & ready_out & ~we_in): data captured on the accept edge.
  - OUT_REG=0: rd_out/rd_valid_out update on that edge, visible the following cycle.
  - OUT_REG=1: one additional cycle.
- A write does not produce rd_valid_out or change rd_out.
- Read-during-write is not possible (single port).
- Back-to-back reads are accepted every cycle; throughput is 1 request/cycle in READY.
- rd_out holds its last value when no read completes; it is not driven to X.
- Out-of-range address (addr_in >= WORD_DEPTH): the write is dropped; the read returns INIT_VALUE with rd_valid_out pulsed normally.
- Re-init with a read in flight (OUT_REG=1): the in-flight read completes with its pre-clear data.
- Reset mid-CLEAR or mid-pipeline: the counter restarts at 0, in-flight reads are discarded (no rd_valid_out), and memory contents are not touched during reset.
- X handling (simulation only, corrupt_mem_on_X_p=1): an accepted request with X on we_in or addr_in sets all words to X and prints a warning. rd_valid_out still pulses if the request was taken as a read.

Test Plan:
- Default params, reset 3 cycles then release -> ready_out=0 for exactly 512 cycles, rises on the 512th edge. A subsequent read of addr 0x1FF returns 0x00 with rd_valid_out pulsed 1 cycle after accept.
- Write addr 0x010, wd=0xA5, mask=0xFF; then write wd=0x3C, mask=0x0F; then read 0x010 -> rd_out=0xAC.
- OUT_REG=1: reads of 0x001, 0x002, 0x003 on consecutive cycles after writing 0x11, 0x22, 0x33 -> rd_valid_out high on three consecutive cycles starting 2 cycles after the first accept; data 0x11, 0x22, 0x33.
- After writing 0x5A to addr 7, pulse init_in together with a ce_in write of 0xFF to addr 8:
  - ready_out drops for 512 cycles;
  - addr 8 write is dropped;
  - reads of 7 and 8 afterwards return INIT_VALUE;
  - ce_in during CLEAR yields no rd_valid_out.
- WORD_DEPTH=5, ADDR_WIDTH=3, INIT_VALUE=0x3C:
  - ready_out rises 5 cycles after reset release;
  - a write to addr 6 is ignored;
  - a read of addr 6 returns 0x3C;
  - a read of addr 4 returns 0x3C.
- Assert reset_in 100 cycles into CLEAR, hold 2 cycles, release -> ready_out rises exactly 512 cycles after the second release. Read-then-reset with OUT_REG=1 -> no rd_valid_out pulse.
